memory_cycle: RTL

- Memory (M) stage of the 5-stage pipelined RISC-V core.
- Consumes the E/M pipeline register outputs of the execute stage.
- Performs data-memory load/store against an internal word-addressed data memory with configurable wait-state latency, and drives StallM to the hazard unit while an access is pending.
- Registers results into the M/W pipeline register that feeds the writeback stage.

---
 rtl/memory_cycle_if.sv | 49 ++++
 rtl/memory_cycle.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/memory_cycle_if.sv
// rtl/memory_cycle_if.sv - E/M inputs and M/W outputs of the memory stage
//
// Purpose: bundles the pipeline-register signals entering and leaving the
// memory stage. Optional MisalignW is present only with MISALIGN_TRAP_EN.
//
// Ports (signals):
//   RegWriteM, MemWriteM, ResultSrcM, RD_M[4:0], PCPlus4M[31:0],
//   WriteDataM[31:0], ALU_ResultM[31:0]   upstream -> memory stage
//   StallM                                memory stage -> hazard unit
//   RegWriteW, ResultSrcW, RD_W[4:0], PCPlus4W[31:0], ALU_ResultW[31:0],
//   ReadDataW[31:0], MisalignW (opt)      memory stage -> writeback
//
// Modports: master = upstream/writeback side, slave = memory stage.
interface memory_cycle_if;
  logic        RegWriteM;
  logic        MemWriteM;
  logic        ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M;
  logic [31:0] WriteDataM;
  logic [31:0] ALU_ResultM;

  logic        StallM;
  logic        RegWriteW;
  logic        ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W;
  logic [31:0] ALU_ResultW;
  logic [31:0] ReadDataW;
`ifdef MISALIGN_TRAP_EN
  logic        MisalignW;
`endif

  modport master (
`ifdef MISALIGN_TRAP_EN
    input  MisalignW,
`endif
    output RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM,
    input  StallM, RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW
  );

  modport slave (
`ifdef MISALIGN_TRAP_EN
    output MisalignW,
`endif
    input  RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM,
    output StallM, RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW
  );
endinterface

// File: rtl/memory_cycle.sv
// rtl/memory_cycle.sv - RISC-V memory stage with wait-state data memory
//
// Purpose: performs loads/stores against an internal word-addressed data
// memory that takes MEM_LATENCY wait cycles per access, stalls upstream via
// StallM while waiting, and registers the M/W pipeline register.
// Optional feature macro: MISALIGN_TRAP_EN (adds MisalignW, suppresses
// misaligned stores and register writes).
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - memory_cycle_if.slave: E/M inputs, StallM, M/W outputs
//
// Parameters:
//   MEM_DEPTH   - data memory words (power of 2)
//   MEM_LATENCY - wait cycles per access (0..15)
module memory_cycle #(
  parameter int MEM_DEPTH   = 1024,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  memory_cycle_if.slave        bus
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [3:0] LAT_M1 = (MEM_LATENCY > 0) ? 4'(MEM_LATENCY - 1) : 4'd0;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        reg_write_w_q, reg_write_w_d;
  logic        result_src_w_q, result_src_w_d;
  logic [4:0]  rd_w_q, rd_w_d;
  logic [31:0] pc_plus4_w_q, pc_plus4_w_d;
  logic [31:0] alu_result_w_q, alu_result_w_d;
  logic [31:0] read_data_w_q, read_data_w_d;
  logic        misalign_w_q, misalign_w_d;

  logic [31:0] mem [MEM_DEPTH];

  logic          access;
  logic          stall;
  logic          commit;
  logic          misaligned;
  logic [AW-1:0] idx;
  logic [31:0]   rd_data;

  assign access  = bus.MemWriteM | (bus.RegWriteM & bus.ResultSrcM);
  // Upper address bits fall off here, so addresses wrap modulo MEM_DEPTH*4.
  assign idx     = bus.ALU_ResultM[AW+1:2];
  assign rd_data = mem[idx];

`ifdef MISALIGN_TRAP_EN
  assign misaligned = access & (bus.ALU_ResultM[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Next state / stall / commit decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && (MEM_LATENCY > 0)) begin
          stall   = 1'b1;
          state_d = WAIT;
          cnt_d   = LAT_M1;
        end else begin
          commit = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    // Reset forces the stage quiet immediately, not only at the next edge.
    if (rst) begin
      stall  = 1'b0;
      commit = 1'b0;
    end
  end

  // M/W register next values: load on commit, bubble while stalled.
  always_comb begin
    reg_write_w_d  = 1'b0;
    result_src_w_d = 1'b0;
    rd_w_d         = 5'd0;
    pc_plus4_w_d   = pc_plus4_w_q;
    alu_result_w_d = alu_result_w_q;
    read_data_w_d  = read_data_w_q;
    misalign_w_d   = 1'b0;
    if (commit) begin
      reg_write_w_d  = bus.RegWriteM & ~misaligned;
      result_src_w_d = bus.ResultSrcM;
      rd_w_d         = bus.RD_M;
      pc_plus4_w_d   = bus.PCPlus4M;
      alu_result_w_d = bus.ALU_ResultM;
      read_data_w_d  = rd_data;
      misalign_w_d   = misaligned;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= 1'b0;
      rd_w_q         <= 5'd0;
      pc_plus4_w_q   <= 32'd0;
      alu_result_w_q <= 32'd0;
      read_data_w_q  <= 32'd0;
      misalign_w_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      reg_write_w_q  <= reg_write_w_d;
      result_src_w_q <= result_src_w_d;
      rd_w_q         <= rd_w_d;
      pc_plus4_w_q   <= pc_plus4_w_d;
      alu_result_w_q <= alu_result_w_d;
      read_data_w_q  <= read_data_w_d;
      misalign_w_q   <= misalign_w_d;
    end
  end

  // Memory contents survive reset; commit is already masked by rst, so a
  // store caught by reset mid-wait is dropped.
  always_ff @(posedge clk) begin
    if (commit && bus.MemWriteM && !misaligned) begin
      mem[idx] <= bus.WriteDataM;
    end
  end

  assign bus.StallM      = stall;
  assign bus.RegWriteW   = reg_write_w_q;
  assign bus.ResultSrcW  = result_src_w_q;
  assign bus.RD_W        = rd_w_q;
  assign bus.PCPlus4W    = pc_plus4_w_q;
  assign bus.ALU_ResultW = alu_result_w_q;
  assign bus.ReadDataW   = read_data_w_q;
`ifdef MISALIGN_TRAP_EN
  assign bus.MisalignW   = misalign_w_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_w_q;
`endif

endmodule
